// File: rtl/cpld4_frame_scanner_pkg.sv
// Shared constants and types for the CPLD4 frame scanner. The same values
// are used by the CPLD3 row generator and its bench.
package cpld4_pkg;

    localparam int unsigned ROWS          = 8;
    localparam int unsigned COLS          = 5;
    localparam int unsigned ROW_W         = 3;
    localparam int unsigned SEL_VALID_BIT = 3;
    localparam int unsigned SEL_IDX_MSB   = 2;
    localparam int unsigned SEL_W         = SEL_VALID_BIT + 1;
    localparam int unsigned DWELL         = 16;
    localparam int unsigned DWELL_W       = $clog2(DWELL);

    // Row select bus from CPLD3: strobe in the MSB, row index below it.
    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] idx;
    } sel_t;

    typedef logic [COLS-1:0] row_word_t;

    // One-hot row select for the LED matrix.
    function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
        return ROWS'(1) << r;
    endfunction

endpackage

// File: rtl/cpld4_frame_scanner_scan_ctr.sv
// Scan timer: holds each row for DWELL clocks and walks rows 0..ROWS-1.
// Ports:
//   clk, rst         clock, async active-low reset
//   scan_row_nxt_c   row that will be displayed after this edge
//   frame_wrap_c     high on the edge that moves from the last row to row 0
module cpld4_scan_ctr
    import cpld4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [ROW_W-1:0] scan_row_nxt_c,
    output logic             frame_wrap_c
);

    logic [DWELL_W-1:0] dwell;
    logic [ROW_W-1:0]   scan_row;
    logic               dwell_end_c;
    logic               row_last_c;

    // Row advance and frame wrap decode.
    always_comb begin
        dwell_end_c    = (dwell == DWELL_W'(DWELL - 1));
        row_last_c     = (scan_row == ROW_W'(ROWS - 1));
        frame_wrap_c   = dwell_end_c && row_last_c;
        scan_row_nxt_c = scan_row;
        if (dwell_end_c) begin
            scan_row_nxt_c = row_last_c ? '0 : scan_row + ROW_W'(1);
        end
    end

    // Dwell and row counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell    <= '0;
            scan_row <= '0;
        end else begin
            dwell    <= dwell_end_c ? '0 : dwell + DWELL_W'(1);
            scan_row <= scan_row_nxt_c;
        end
    end

endmodule

// File: rtl/cpld4_frame_scanner.sv
// Captures CPLD3 row words into a ping-pong frame buffer and scans the
// completed (front) bank onto a multiplexed LED matrix. Banks swap only at
// a scan-frame boundary so the display never tears.
// Ports:
//   clk, rst      clock, async active-low reset
//   row_data_in   row word to store
//   sel_in        [3] row strobe, [2:0] row index
//   last_row_in   final row of the frame (qualified by the strobe)
//   led_col       column drive for the current scan row
//   led_row       one-hot row select
//   frame_ready   one-cycle pulse when a new frame becomes the front bank
//   overrun       sticky: a row write was dropped while a frame was pending
module cpld4_frame_scanner
    import cpld4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [COLS-1:0]  row_data_in,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             last_row_in,
    output logic [COLS-1:0]  led_col,
    output logic [ROWS-1:0]  led_row,
    output logic             frame_ready,
    output logic             overrun
);

    logic [ROWS-1:0][COLS-1:0] banks [2];
    logic                      bank_sel;
    logic                      pending;

    sel_t             sel_c;
    logic             wr_en_c;
    logic             drop_c;
    logic             swap_c;
    logic             back_sel_c;
    logic             front_nxt_c;
    logic [ROW_W-1:0] scan_row_nxt_c;
    logic             frame_wrap_c;

    cpld4_scan_ctr u_scan_ctr (
        .clk            (clk),
        .rst            (rst),
        .scan_row_nxt_c (scan_row_nxt_c),
        .frame_wrap_c   (frame_wrap_c)
    );

    // Write/drop/swap decode. Writes and swaps are exclusive through pending.
    always_comb begin
        sel_c       = sel_t'(sel_in);
        wr_en_c     = sel_c.valid && !pending;
        drop_c      = sel_c.valid && pending;
        swap_c      = frame_wrap_c && pending;
        back_sel_c  = ~bank_sel;
        front_nxt_c = swap_c ? ~bank_sel : bank_sel;
    end

    // Frame buffer: only the back bank is ever written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            banks[0] <= '0;
            banks[1] <= '0;
        end else if (wr_en_c) begin
            banks[back_sel_c][sel_c.idx] <= row_data_in;
        end
    end

    // Bank control and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_sel    <= 1'b0;
            pending     <= 1'b0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_ready <= swap_c;
            overrun     <= overrun | drop_c;
            if (swap_c) begin
                bank_sel <= ~bank_sel;
                pending  <= 1'b0;
            end else if (wr_en_c && last_row_in) begin
                pending <= 1'b1;
            end
        end
    end

    // LED drive registered from the next row and next front bank so it stays
    // aligned with the scan counter, including row 0 right after a swap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_col <= '0;
            led_row <= ROWS'(1);
        end else begin
            led_col <= banks[front_nxt_c][scan_row_nxt_c];
            led_row <= row_onehot(scan_row_nxt_c);
        end
    end

endmodule

// File: tb/tb_cpld4_frame_scanner.sv
// Scoreboard bench for cpld4_frame_scanner with an arithmetic reference model.
module tb_cpld4_frame_scanner;

    localparam int NR    = 8;
    localparam int DW    = 16;
    localparam int FRAME = NR * DW;

    logic       clk;
    logic       rst;
    logic [4:0] row_data_in;
    logic [3:0] sel_in;
    logic       last_row_in;
    logic [4:0] led_col;
    logic [7:0] led_row;
    logic       frame_ready;
    logic       overrun;

    cpld4_frame_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .row_data_in (row_data_in),
        .sel_in      (sel_in),
        .last_row_in (last_row_in),
        .led_col     (led_col),
        .led_row     (led_row),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] row;
        logic [4:0] col;
        logic       fr;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fr_seen = 0;

    // Reference model: display position derived from the edge count.
    logic [4:0] m_front [NR];
    logic [4:0] m_back  [NR];
    bit         m_pend;
    bit         m_ov;
    bit         m_fr;
    int         m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            m_front[i] = '0;
            m_back[i]  = '0;
        end
        m_pend = 0;
        m_ov   = 0;
        m_fr   = 0;
        m_cnt  = 0;
    endfunction

    function automatic void model_step();
        bit         wrap;
        bit         swap;
        logic [4:0] t;
        if (!rst) begin
            model_reset();
            return;
        end
        wrap = ((m_cnt % FRAME) == FRAME - 1);
        swap = wrap && m_pend;
        m_fr = swap;
        if (sel_in[3]) begin
            if (m_pend) m_ov = 1;
            else begin
                m_back[sel_in[2:0]] = row_data_in;
                if (last_row_in) m_pend = 1;
            end
        end
        if (swap) begin
            for (int i = 0; i < NR; i++) begin
                t = m_front[i];
                m_front[i] = m_back[i];
                m_back[i] = t;
            end
            m_pend = 0;
        end
        m_cnt++;
    endfunction

    function automatic int model_row();
        return (m_cnt / DW) % NR;
    endfunction

    function automatic void push_exp();
        exp_t e;
        int   r;
        r     = model_row();
        e.row = 8'(1 << r);
        e.col = m_front[r];
        e.fr  = m_fr;
        e.ov  = m_ov;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard once per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led_row", int'(led_row), int'(e.row));
            check("led_col", int'(led_col), int'(e.col));
            check("frame_ready", int'(frame_ready), int'(e.fr));
            check("overrun", int'(overrun), int'(e.ov));
            if (frame_ready) fr_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        push_exp();
    endtask

    task automatic drive(input bit v, input int idx, input logic [4:0] d, input bit last);
        sel_in      = {v, 3'(idx)};
        row_data_in = d;
        last_row_in = last;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 5'h00, 0);
    endtask

    task automatic reset_now();
        sel_in      = '0;
        row_data_in = '0;
        last_row_in = 1'b0;
        @(posedge clk);
        #1;
        model_step();
        rst = 1'b0;
        model_reset();
        push_exp();
    endtask

    logic [4:0] pat [NR];
    int         fr_before;
    int         guard;

    initial begin
        pat[0] = 5'h01; pat[1] = 5'h02; pat[2] = 5'h04; pat[3] = 5'h08;
        pat[4] = 5'h10; pat[5] = 5'h1F; pat[6] = 5'h00; pat[7] = 5'h15;
        rst         = 1'b0;
        sel_in      = '0;
        row_data_in = '0;
        last_row_in = 1'b0;
        model_reset();

        // Reset held three cycles, then rows step every DWELL clocks.
        idle(3);
        rst = 1'b1;
        idle(40);

        // last_row_in without the strobe is ignored.
        for (int i = 0; i < 6; i++) drive(0, 7, 5'h1F, 1);
        idle(FRAME + 20);
        check("no_frame_ignored_last", fr_seen, 0);

        // Full frame with fixed pattern, last on row 7.
        for (int i = 0; i < NR; i++) drive(1, i, pat[i], i == NR - 1);
        idle(FRAME + 40);
        check("one_frame_after_full", fr_seen, 1);

        // Overrun: new frame completes, then row 2 write is dropped.
        for (int i = 0; i < NR; i++) drive(1, i, 5'($urandom_range(0, 31)), i == NR - 1);
        drive(1, 2, 5'h1F, 0);
        guard = 0;
        while (m_pend && guard < 2 * FRAME) begin idle(1); guard++; end
        check("overrun_swap_reached", int'(m_pend), 0);
        idle(FRAME);

        // Wrap collision: row 7 with last lands exactly on the wrap edge.
        guard = 0;
        while ((m_cnt % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin idle(1); guard++; end
        fr_before = fr_seen;
        drive(1, 7, 5'h0A, 1);
        idle(FRAME - 2);
        check("collision_no_early_frame", fr_seen, fr_before);
        idle(4);
        check("collision_frame_after_wrap", fr_seen, fr_before + 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit v;
            v = ($urandom_range(0, 3) == 0);
            drive(v, $urandom_range(0, 7), 5'($urandom_range(0, 31)),
                  v ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) == 0));
        end

        // Reset mid-scan with a frame pending at scan row 5.
        guard = 0;
        while (m_pend && guard < 2 * FRAME) begin idle(1); guard++; end
        guard = 0;
        while (model_row() != 0 && guard < 2 * FRAME) begin idle(1); guard++; end
        for (int i = 0; i < NR; i++) drive(1, i, 5'($urandom_range(1, 31)), i == NR - 1);
        guard = 0;
        while (model_row() != 5 && guard < 2 * FRAME) begin idle(1); guard++; end
        check("pending_before_reset", int'(m_pend), 1);
        reset_now();
        idle(2);
        rst = 1'b1;
        fr_before = fr_seen;
        idle(FRAME * 2 + 10);
        check("no_frame_after_reset", fr_seen, fr_before);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
